axi_lite_regfile_slave: RTL and testbench
=========================================

AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, meaning the byte-address width of AWADDR and ARADDR.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, meaning the number of implemented registers; legal range is 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: ACLK  input  1  clock, all logic on the rising edge.
REQ-005 ARESETn  input  1  synchronous active-low reset.
REQ-006 AWADDR  input  ADDR_WIDTH  write byte address; AWVALID  input  1; AWREADY  output  1.
REQ-007 WDATA  input  DATA_WIDTH; WSTRB  input  DATA_WIDTH/8  byte enables; WVALID  input  1; WREADY  output  1.
REQ-008 BVALID  output  1; BRESP  output  2  write response; BREADY  input  1.
REQ-009 ARADDR  input  ADDR_WIDTH  read byte address; ARVALID  input  1; ARREADY  output  1.
REQ-010 RDATA  output  DATA_WIDTH; RRESP  output  2  read response; RVALID  output  1; RREADY  input  1.

Function
REQ-011 The register index SHALL be addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; the low address bits SHALL be ignored. An index >= NUM_REGS is out of range.
REQ-012 The write FSM SHALL have the states W_IDLE and W_RESP; AWREADY and WREADY SHALL be registered outputs.
REQ-013 In W_IDLE, AW and W SHALL be accepted independently in any order or in the same cycle; after its handshake, each READY SHALL drop until the next return to W_IDLE.
REQ-014 On the edge where the second of AW and W completes, the write SHALL commit, only bytes with WSTRB[i]=1 SHALL update, and the FSM SHALL enter W_RESP with BVALID=1 on the following cycle (latency 1).
REQ-015 In W_RESP, BVALID and BRESP SHALL hold stable until BREADY=1; on that edge the FSM SHALL return to W_IDLE with AWREADY=WREADY=1 in the next cycle.
REQ-016 The read FSM SHALL have the states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-017 On an AR handshake, RDATA SHALL be registered from the addressed register and RVALID SHALL assert on the next cycle (latency 1).
REQ-018 RDATA, RRESP and RVALID SHALL hold stable until RREADY=1; the FSM SHALL then return to R_IDLE.
REQ-019 The read and write channels SHALL operate concurrently. If a write commits on the same edge as an AR handshake to the same register, RDATA SHALL return the pre-write value.
REQ-020 A write with WSTRB=0 SHALL leave the register unchanged and still return a response.
REQ-021 An out-of-range write SHALL modify no register; an out-of-range read SHALL return RDATA=0. The response code follows REQ-026/027.

Reset
REQ-022 While ARESETn=0 at a rising edge, all registers SHALL clear to 0, the FSMs SHALL go to W_IDLE/R_IDLE, and AWREADY, WREADY, ARREADY, BVALID and RVALID SHALL be 0. RDATA, BRESP and RRESP SHALL be 0.
REQ-023 AWREADY, WREADY and ARREADY SHALL rise to 1 at the first rising edge sampled with ARESETn=1.
REQ-024 A reset asserted mid-transaction SHALL abort the transaction with no response issued. A write that has not committed SHALL NOT alter any register.

Configuration
REQ-025 The macro AXIL_SLVERR_EN SHALL select out-of-range error signalling.
REQ-026 With AXIL_SLVERR_EN defined, an out-of-range access SHALL return BRESP/RRESP=2'b10 (SLVERR); in-range accesses SHALL return 2'b00.
REQ-027 Without AXIL_SLVERR_EN, all responses SHALL be 2'b00 (OKAY), and out-of-range behaviour SHALL otherwise match REQ-021.

Verification
REQ-028 Reset, then read address 0x08 -> ARREADY=1 on the first cycle after reset release; RVALID one cycle after the handshake; RDATA=0x0, RRESP=00.
REQ-029 Write 0x04 with WDATA=0xDEADBEEF and WSTRB=4'b0101, then read 0x04 -> RDATA=0x00AD00EF, BRESP=00.
REQ-030 Send W two cycles before AW, with BREADY held 0 for 3 cycles -> no commit before AW; BVALID stays high for 3 cycles; AWREADY=WREADY=0 until B completes.
REQ-031 Write 0x3C with WDATA=0x11111111, WSTRB=F (index 15, in range), and write 0x40 with ADDR_WIDTH=7, NUM_REGS=16 (out of range) -> first gives BRESP=00; second gives BRESP=10 with the macro, 00 without; a read of 0x40 returns 0.
REQ-032 Same-edge write of 0x22222222 to 0x0C and AR handshake to 0x0C, with the register initially 0x11111111 -> RDATA=0x11111111; a subsequent read returns 0x22222222.
REQ-033 Drive ARESETn=0 after the AW handshake but before W -> no BVALID, register unchanged, and ready signals recover 1 cycle after release.

Source files
------------

// File: rtl/axi_lite_regfile_slave_if.sv
// AXI4-Lite bus bundle for axi_lite_regfile_slave (AW, W, B, AR, R channels).
interface axi_lite_regfile_slave_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;

   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_WIDTH-1:0] WSTRB;
   logic                  WVALID;
   logic                  WREADY;

   logic                  BVALID;
   logic [1:0]            BRESP;
   logic                  BREADY;

   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite register file slave: NUM_REGS registers of DATA_WIDTH bits,
// independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs.
// Optional macro AXIL_SLVERR_EN: out-of-range accesses respond SLVERR (2'b10)
// instead of OKAY.
module axi_lite_regfile_slave #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input logic                     ACLK,
   input logic                     ARESETn,
   axi_lite_regfile_slave_if.slave s_axi
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned IDX_LSB    = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - IDX_LSB;

   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] RESP_OOR  = 2'b10;
`else
   localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // write channel state
   wstate_t               r_wstate, w_wstate_nxt;
   logic                  r_awready, w_awready_nxt;
   logic                  r_wready, w_wready_nxt;
   logic                  r_bvalid, w_bvalid_nxt;
   logic [1:0]            r_bresp, w_bresp_nxt;
   logic                  r_aw_done, r_w_done;
   logic [IDX_WIDTH-1:0]  r_aw_idx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;

   // read channel state
   rstate_t               r_rstate, w_rstate_nxt;
   logic                  r_arready, w_arready_nxt;
   logic                  r_rvalid, w_rvalid_nxt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   logic                  w_aw_hs, w_w_hs, w_ar_hs;
   logic                  w_have_aw, w_have_w, w_commit;
   logic [IDX_WIDTH-1:0]  w_wr_idx, w_ar_idx;
   logic [DATA_WIDTH-1:0] w_wr_data, w_ar_data;
   logic [STRB_WIDTH-1:0] w_wr_strb;
   logic                  w_wr_in_range, w_ar_in_range;

   assign w_aw_hs   = s_axi.AWVALID & r_awready;
   assign w_w_hs    = s_axi.WVALID  & r_wready;
   assign w_ar_hs   = s_axi.ARVALID & r_arready;

   // The write commits on the edge where the later of AW and W completes.
   assign w_have_aw = r_aw_done | w_aw_hs;
   assign w_have_w  = r_w_done  | w_w_hs;
   assign w_commit  = (r_wstate == W_IDLE) & w_have_aw & w_have_w;

   assign w_wr_idx  = r_aw_done ? r_aw_idx : s_axi.AWADDR[ADDR_WIDTH-1:IDX_LSB];
   assign w_wr_data = r_w_done  ? r_wdata  : s_axi.WDATA;
   assign w_wr_strb = r_w_done  ? r_wstrb  : s_axi.WSTRB;
   assign w_ar_idx  = s_axi.ARADDR[ADDR_WIDTH-1:IDX_LSB];

   // Address decode: range check and read mux (unmatched index reads as 0).
   always_comb begin
      w_wr_in_range = 1'b0;
      w_ar_in_range = 1'b0;
      w_ar_data     = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (w_wr_idx == IDX_WIDTH'(i)) w_wr_in_range = 1'b1;
         if (w_ar_idx == IDX_WIDTH'(i)) begin
            w_ar_in_range = 1'b1;
            w_ar_data     = r_regs[i];
         end
      end
   end

   // Register file: byte-masked update on commit, cleared by reset.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_wr_idx == IDX_WIDTH'(i)) begin
               for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                  if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Write FSM state register plus registered outputs and captured halves.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_aw_idx  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_bresp   <= w_bresp_nxt;
         r_aw_done <= w_have_aw & ~w_commit;
         r_w_done  <= w_have_w  & ~w_commit;
         if (w_aw_hs) r_aw_idx <= s_axi.AWADDR[ADDR_WIDTH-1:IDX_LSB];
         if (w_w_hs) begin
            r_wdata <= s_axi.WDATA;
            r_wstrb <= s_axi.WSTRB;
         end
      end
   end

   // Write FSM next state.
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_commit)     w_wstate_nxt = W_RESP;
         W_RESP:  if (s_axi.BREADY) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   // Write FSM outputs: each READY drops after its handshake until back in idle.
   always_comb begin
      w_awready_nxt = 1'b0;
      w_wready_nxt  = 1'b0;
      w_bvalid_nxt  = 1'b0;
      w_bresp_nxt   = r_bresp;
      case (r_wstate)
         W_IDLE: begin
            w_awready_nxt = ~w_have_aw;
            w_wready_nxt  = ~w_have_w;
            w_bvalid_nxt  = w_commit;
            if (w_commit) w_bresp_nxt = w_wr_in_range ? RESP_OKAY : RESP_OOR;
         end
         W_RESP: begin
            w_awready_nxt = s_axi.BREADY;
            w_wready_nxt  = s_axi.BREADY;
            w_bvalid_nxt  = ~s_axi.BREADY;
         end
         default: ;
      endcase
   end

   // Read FSM state register plus registered outputs; data sampled pre-write.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_rstate  <= w_rstate_nxt;
         r_arready <= w_arready_nxt;
         r_rvalid  <= w_rvalid_nxt;
         if (w_ar_hs) begin
            r_rdata <= w_ar_data;
            r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_OOR;
         end
      end
   end

   // Read FSM next state.
   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
         R_DATA:  if (s_axi.RREADY) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // Read FSM outputs.
   always_comb begin
      w_arready_nxt = 1'b0;
      w_rvalid_nxt  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready_nxt = ~w_ar_hs;
            w_rvalid_nxt  = w_ar_hs;
         end
         R_DATA: begin
            w_arready_nxt = s_axi.RREADY;
            w_rvalid_nxt  = ~s_axi.RREADY;
         end
         default: ;
      endcase
   end

   assign s_axi.AWREADY = r_awready;
   assign s_axi.WREADY  = r_wready;
   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign s_axi.ARREADY = r_arready;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Bench for axi_lite_regfile_slave: directed AXI-Lite traffic, a transaction-level
// reference model checked every cycle, and literal expectations on key results.
module tb_axi_lite_regfile_slave;
   localparam int unsigned AW = 7;
   localparam int unsigned DW = 32;
   localparam int NR = 16;
`ifdef AXIL_SLVERR_EN
   localparam logic [1:0] EXP_OOR = 2'b10;
`else
   localparam logic [1:0] EXP_OOR = 2'b00;
`endif

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_lite_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents and outstanding responses as queues.
   typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
   logic [31:0] m_regs [NR];
   logic [1:0]  bq [$];
   rexp_t       rq [$];
   logic        m_aw_pend, m_w_pend;
   logic [6:0]  m_awaddr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        rst_at_edge;

   always @(posedge ACLK) rst_at_edge <= ARESETn;

   // Compare DUT outputs to the model each cycle, then advance the model.
   always @(negedge ACLK) begin
      int idx;
      rexp_t re;
      if (!rst_at_edge) begin
         chk("reset_ctrl", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                bus.BRESP, bus.RRESP}), 64'(0));
         chk("reset_rdata", 64'(bus.RDATA), 64'(0));
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
         bq.delete();
         rq.delete();
         m_aw_pend = 1'b0;
         m_w_pend  = 1'b0;
      end else begin
         chk("awready", 64'(bus.AWREADY), 64'(!m_aw_pend && bq.size() == 0));
         chk("wready",  64'(bus.WREADY),  64'(!m_w_pend && bq.size() == 0));
         chk("arready", 64'(bus.ARREADY), 64'(rq.size() == 0));
         chk("bvalid",  64'(bus.BVALID),  64'(bq.size() != 0));
         chk("rvalid",  64'(bus.RVALID),  64'(rq.size() != 0));
         if (bus.BVALID && bq.size() != 0) chk("bresp", 64'(bus.BRESP), 64'(bq[0]));
         if (bus.RVALID && rq.size() != 0) begin
            chk("rdata", 64'(bus.RDATA), 64'(rq[0].data));
            chk("rresp", 64'(bus.RRESP), 64'(rq[0].resp));
         end
      end
      if (ARESETn) begin
         if (bus.BVALID && bus.BREADY && bq.size() != 0) void'(bq.pop_front());
         if (bus.RVALID && bus.RREADY && rq.size() != 0) void'(rq.pop_front());
         if (bus.ARVALID && bus.ARREADY) begin
            idx = int'(bus.ARADDR) / 4;
            re.data = (idx < NR) ? m_regs[idx] : 32'h0;
            re.resp = (idx < NR) ? 2'b00 : EXP_OOR;
            rq.push_back(re);
         end
         if (bus.AWVALID && bus.AWREADY) begin
            m_aw_pend = 1'b1;
            m_awaddr  = bus.AWADDR;
         end
         if (bus.WVALID && bus.WREADY) begin
            m_w_pend = 1'b1;
            m_wdata  = bus.WDATA;
            m_wstrb  = bus.WSTRB;
         end
         if (m_aw_pend && m_w_pend) begin
            idx = int'(m_awaddr) / 4;
            if (idx < NR)
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
            bq.push_back((idx < NR) ? 2'b00 : EXP_OOR);
            m_aw_pend = 1'b0;
            m_w_pend  = 1'b0;
         end
      end
   end

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
   task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int b_hold,
                           output logic [1:0] resp, output int b_wait);
      bit aw_ok = 0, w_ok = 0, a_hs, w_hs, got = 0;
      int n = 0;
      int alead = (lead < 0) ? -lead : lead;
      @(posedge ACLK); #1;
      bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = s;
      bus.AWVALID = (lead <= 0);
      bus.WVALID  = (lead >= 0);
      while (!(aw_ok && w_ok) && n < 50) begin
         @(negedge ACLK);
         a_hs = bus.AWVALID && bus.AWREADY;
         w_hs = bus.WVALID && bus.WREADY;
         @(posedge ACLK); #1;
         if (a_hs) begin aw_ok = 1; bus.AWVALID = 1'b0; end
         if (w_hs) begin w_ok = 1; bus.WVALID = 1'b0; end
         n++;
         if (n == alead) begin
            if (lead > 0 && !aw_ok) bus.AWVALID = 1'b1;
            if (lead < 0 && !w_ok)  bus.WVALID  = 1'b1;
         end
      end
      chk("write_addr_data_accepted", 64'(aw_ok && w_ok), 64'(1));
      bus.BREADY = (b_hold == 0);
      b_wait = 0;
      resp = 2'bxx;
      n = 0;
      while (!got && n < 60) begin
         @(negedge ACLK);
         n++;
         if (bus.BVALID && bus.BREADY) begin got = 1; resp = bus.BRESP; end
         else if (bus.BVALID) b_wait++;
         @(posedge ACLK); #1;
         if (!got && b_wait >= b_hold) bus.BREADY = 1'b1;
      end
      bus.BREADY = 1'b0;
      chk("bvalid_seen", 64'(got), 64'(1));
   endtask

   task automatic do_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int lat);
      bit hs = 0, got = 0;
      int n = 0;
      @(posedge ACLK); #1;
      bus.ARADDR = a;
      bus.ARVALID = 1'b1;
      while (!hs && n < 50) begin
         @(negedge ACLK);
         hs = bus.ARVALID && bus.ARREADY;
         @(posedge ACLK); #1;
         n++;
      end
      bus.ARVALID = 1'b0;
      chk("ar_accepted", 64'(hs), 64'(1));
      bus.RREADY = 1'b1;
      lat = 0; d = 'x; r = 'x;
      while (!got && lat < 50) begin
         @(negedge ACLK);
         lat++;
         if (bus.RVALID) begin got = 1; d = bus.RDATA; r = bus.RRESP; end
      end
      @(posedge ACLK); #1;
      bus.RREADY = 1'b0;
      chk("rvalid_seen", 64'(got), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r, br;
      int lat, bw, n;
      logic [31:0] d2;
      logic [1:0]  r2, br2;
      int lat2, bw2;
      bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

      // reset release and first read
      repeat (3) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      @(negedge ACLK); chk("arready_last_reset_cycle", 64'(bus.ARREADY), 64'(0));
      @(negedge ACLK); chk("arready_after_release", 64'(bus.ARREADY), 64'(1));
      chk("awready_after_release", 64'(bus.AWREADY), 64'(1));
      do_read(7'h08, d, r, lat);
      chk("rd08_data", 64'(d), 64'h0);
      chk("rd08_resp", 64'(r), 64'h0);
      chk("rd08_latency", 64'(lat), 64'd1);

      // partial strobes
      do_write(7'h04, 32'hDEADBEEF, 4'b0101, 0, 0, br, bw);
      chk("wr04_bresp", 64'(br), 64'h0);
      do_read(7'h04, d, r, lat);
      chk("rd04_data", 64'(d), 64'h00AD00EF);

      // W two cycles ahead of AW, B held off for three cycles
      do_write(7'h14, 32'hA5A5A5A5, 4'hF, 2, 3, br, bw);
      chk("wr14_bwait", 64'(bw), 64'd3);
      chk("wr14_bresp", 64'(br), 64'h0);
      do_read(7'h14, d, r, lat);
      chk("rd14_data", 64'(d), 64'hA5A5A5A5);

      // AW two cycles ahead of W, upper bytes only
      do_write(7'h18, 32'h12345678, 4'b1100, -2, 0, br, bw);
      do_read(7'h18, d, r, lat);
      chk("rd18_data", 64'(d), 64'h12340000);

      // last in-range register and first out-of-range address
      do_write(7'h3C, 32'h11111111, 4'hF, 0, 0, br, bw);
      chk("wr3c_bresp", 64'(br), 64'h0);
      do_read(7'h3C, d, r, lat);
      chk("rd3c_data", 64'(d), 64'h11111111);
      do_write(7'h40, 32'h99999999, 4'hF, 0, 0, br, bw);
      chk("wr40_bresp", 64'(br), 64'(EXP_OOR));
      do_read(7'h40, d, r, lat);
      chk("rd40_data", 64'(d), 64'h0);
      chk("rd40_resp", 64'(r), 64'(EXP_OOR));
      do_read(7'h00, d, r, lat);
      chk("rd00_no_alias", 64'(d), 64'h0);

      // write commit and AR handshake on the same edge
      do_write(7'h0C, 32'h11111111, 4'hF, 0, 0, br, bw);
      fork
         do_write(7'h0C, 32'h22222222, 4'hF, 0, 0, br2, bw2);
         do_read(7'h0C, d2, r2, lat2);
      join
      chk("same_edge_old_data", 64'(d2), 64'h11111111);
      do_read(7'h0C, d, r, lat);
      chk("same_edge_new_data", 64'(d), 64'h22222222);

      // zero strobe; low address bits ignored on read
      do_write(7'h04, 32'hFFFFFFFF, 4'h0, 0, 0, br, bw);
      chk("wstrb0_bresp", 64'(br), 64'h0);
      do_read(7'h07, d, r, lat);
      chk("wstrb0_data", 64'(d), 64'h00AD00EF);

      // reset between AW handshake and W
      @(posedge ACLK); #1;
      bus.AWADDR = 7'h10; bus.AWVALID = 1'b1; bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF;
      n = 0;
      do begin
         @(negedge ACLK);
         lat = int'(bus.AWREADY);
         @(posedge ACLK); #1;
         n++;
      end while (lat == 0 && n < 20);
      bus.AWVALID = 1'b0;
      chk("abort_aw_accepted", 64'(lat), 64'd1);
      @(negedge ACLK); chk("abort_no_bvalid", 64'(bus.BVALID), 64'(0));
      @(posedge ACLK); #1 ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      @(negedge ACLK); chk("abort_awready_in_reset", 64'(bus.AWREADY), 64'(0));
      @(negedge ACLK);
      chk("abort_ready_recovered", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
      chk("abort_no_bvalid_after", 64'(bus.BVALID), 64'(0));
      do_read(7'h10, d, r, lat);
      chk("abort_reg_not_written", 64'(d), 64'h0);
      do_read(7'h14, d, r, lat);
      chk("reset_cleared_reg", 64'(d), 64'h0);

      repeat (2) @(posedge ACLK);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
